// File: rtl/color_quantizer.sv
// RGB444 -> RGB222 colour quantizer with 2x2 ordered (Bayer) dither and an
// optional per-frame phase flip. Two registered stages, one pixel per clock.
module color_quantizer #(
  parameter int DITHER_EN = 1,
  parameter int TEMPORAL  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        pix_valid,
  input  logic        line_start,
  input  logic        frame_start,
  input  logic [11:0] rgb_in,
  output logic [5:0]  rgb_out,
  output logic        valid_out
);

  localparam int NCH = 3;

  // {v/5, v%5} for a 4-bit level; base reaches 3 only for v=15.
  function automatic logic [4:0] f_split(input logic [3:0] v);
    logic [4:0] s;
    s = '0;
    case (v)
      4'd0:  s = {2'd0, 3'd0};
      4'd1:  s = {2'd0, 3'd1};
      4'd2:  s = {2'd0, 3'd2};
      4'd3:  s = {2'd0, 3'd3};
      4'd4:  s = {2'd0, 3'd4};
      4'd5:  s = {2'd1, 3'd0};
      4'd6:  s = {2'd1, 3'd1};
      4'd7:  s = {2'd1, 3'd2};
      4'd8:  s = {2'd1, 3'd3};
      4'd9:  s = {2'd1, 3'd4};
      4'd10: s = {2'd2, 3'd0};
      4'd11: s = {2'd2, 3'd1};
      4'd12: s = {2'd2, 3'd2};
      4'd13: s = {2'd2, 3'd3};
      4'd14: s = {2'd2, 3'd4};
      4'd15: s = {2'd3, 3'd0};
    endcase
    return s;
  endfunction

  function automatic logic [1:0] f_bayer(input logic row, input logic col);
    logic [1:0] t;
    case ({row, col})
      2'b00:   t = 2'd0;
      2'b01:   t = 2'd2;
      2'b10:   t = 2'd3;
      default: t = 2'd1;
    endcase
    return t;
  endfunction

  logic       r_row_par;
  logic       r_col_par;
  logic       r_fphase;
  logic       w_strobe;
  logic       w_eff_row;
  logic       w_eff_col;
  logic       w_phase_next;
  logic       w_ph;
  logic [1:0] w_t;

  logic [1:0] w_base    [NCH];
  logic [2:0] w_rem     [NCH];
  logic [1:0] r_s1_base [NCH];
  logic [2:0] r_s1_rem  [NCH];
  logic [1:0] r_s1_t;
  logic       r_s1_en;
  logic       r_s1_valid;

  logic       w_bump    [NCH];
  logic [2:0] w_q_wide  [NCH];
  logic [5:0] w_q;
  logic [5:0] r_rgb_out;
  logic       r_valid_out;

  // Position of the pixel on the bus this cycle, strobes taking effect at once.
  assign w_strobe     = line_start | frame_start;
  assign w_eff_row    = frame_start ? 1'b0 : (line_start ? ~r_row_par : r_row_par);
  assign w_eff_col    = w_strobe ? 1'b0 : r_col_par;
  assign w_phase_next = r_fphase ^ frame_start;

  if (TEMPORAL != 0) begin : g_temporal
    assign w_ph = w_phase_next;
  end else begin : g_static
    assign w_ph = 1'b0;
  end

  assign w_t = f_bayer(w_eff_row ^ w_ph, w_eff_col ^ w_ph);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row_par <= 1'b0;
      r_col_par <= 1'b0;
      r_fphase  <= 1'b0;
    end else begin
      r_row_par <= w_eff_row;
      r_col_par <= w_eff_col ^ pix_valid;
      r_fphase  <= w_phase_next;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [4:0] w_split;

    assign w_split    = f_split(rgb_in[4*gi +: 4]);
    assign w_base[gi] = w_split[4:3];
    assign w_rem[gi]  = w_split[2:0];

    if (DITHER_EN != 0) begin : g_dither
      assign w_bump[gi] = (r_s1_rem[gi] > {1'b0, r_s1_t});
    end else begin : g_round
      assign w_bump[gi] = (r_s1_rem[gi] >= 3'd3);
    end

    // One spare bit so an overflow would be visible to the range check.
    assign w_q_wide[gi]   = {1'b0, r_s1_base[gi]} + {2'b00, w_bump[gi]};
    assign w_q[2*gi +: 2] = w_q_wide[gi][1:0];

    a_q_range: assert property (@(posedge clk) disable iff (reset)
      r_s1_valid |-> (w_q_wide[gi] <= 3'd3));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        r_s1_base[i] <= '0;
        r_s1_rem[i]  <= '0;
      end
      r_s1_t     <= '0;
      r_s1_en    <= 1'b0;
      r_s1_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_s1_base[i] <= w_base[i];
        r_s1_rem[i]  <= w_rem[i];
      end
      r_s1_t     <= w_t;
      r_s1_en    <= en;
      r_s1_valid <= pix_valid;
    end
  end

  // Output holds its last pixel across gaps; blanked pixels still count as valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb_out   <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= r_s1_valid;
      if (r_s1_valid) begin
        r_rgb_out <= r_s1_en ? w_q : 6'd0;
      end
    end
  end

  assign rgb_out   = r_rgb_out;
  assign valid_out = r_valid_out;

endmodule

// File: tb/tb_color_quantizer.sv
// Bench for color_quantizer: three parameterisations share one stimulus stream,
// checked against a position-counting reference model plus fixed vector tables.
module tb_color_quantizer;

  logic        clk = 1'b0;
  logic        reset, en, pix_valid, line_start, frame_start;
  logic [11:0] rgb_in;
  logic [5:0]  rgb_dt, rgb_ds, rgb_rn;
  logic        val_dt, val_ds, val_rn;

  always #5 clk = ~clk;

  color_quantizer #(.DITHER_EN(1), .TEMPORAL(1)) u_dt (
    .clk(clk), .reset(reset), .en(en), .pix_valid(pix_valid),
    .line_start(line_start), .frame_start(frame_start), .rgb_in(rgb_in),
    .rgb_out(rgb_dt), .valid_out(val_dt));

  color_quantizer #(.DITHER_EN(1), .TEMPORAL(0)) u_ds (
    .clk(clk), .reset(reset), .en(en), .pix_valid(pix_valid),
    .line_start(line_start), .frame_start(frame_start), .rgb_in(rgb_in),
    .rgb_out(rgb_ds), .valid_out(val_ds));

  color_quantizer #(.DITHER_EN(0), .TEMPORAL(1)) u_rn (
    .clk(clk), .reset(reset), .en(en), .pix_valid(pix_valid),
    .line_start(line_start), .frame_start(frame_start), .rgb_in(rgb_in),
    .rgb_out(rgb_rn), .valid_out(val_rn));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: raster counters plus a two-deep output delay line.
  int         m_frame = 0;
  int         m_line  = 0;
  int         m_pix   = 0;
  logic       m_s1_valid = 1'b0;
  logic [5:0] m_s1_q  [3];
  logic       m_out_valid = 1'b0;
  logic [5:0] m_out_q [3];

  typedef struct {
    logic        en;
    logic        pv;
    logic        ls;
    logic        fs;
    logic [11:0] rgb;
    logic        ev;
    logic [5:0]  e_dt;
    logic [5:0]  e_ds;
    logic [5:0]  e_rn;
  } vec_t;

  localparam int NV = 22;
  vec_t tv [NV];

  function automatic vec_t mk(input logic e, input logic pv, input logic ls, input logic fs,
                              input logic [11:0] rgb, input logic ev,
                              input logic [5:0] dt, input logic [5:0] ds, input logic [5:0] rn);
    vec_t v;
    v.en = e; v.pv = pv; v.ls = ls; v.fs = fs; v.rgb = rgb;
    v.ev = ev; v.e_dt = dt; v.e_ds = ds; v.e_rn = rn;
    return v;
  endfunction

  function automatic int bayer(input int row, input int col);
    if (row == 0) return (col == 0) ? 0 : 2;
    return (col == 0) ? 3 : 1;
  endfunction

  function automatic logic [5:0] ref_pix(input int dither, input int temporal,
                                         input logic [11:0] rgb, input logic e,
                                         input int row, input int col, input int fph);
    logic [5:0] r;
    int ph, t, v, q;
    r  = '0;
    ph = (temporal != 0) ? fph : 0;
    t  = bayer(row ^ ph, col ^ ph);
    for (int ch = 0; ch < 3; ch++) begin
      v = int'(rgb[4*ch +: 4]);
      q = v / 5;
      if (dither != 0) begin
        if ((v % 5) > t) q = q + 1;
      end else if ((v % 5) >= 3) begin
        q = q + 1;
      end
      if (e) r[2*ch +: 2] = 2'(q);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got valid=%b rgb=%b, want valid=%b rgb=%b",
                  name, cyc, act[6], act[5:0], exp[6], exp[5:0]);
  endtask

  task automatic step(input logic i_rst, input logic i_en, input logic i_pv,
                      input logic i_ls, input logic i_fs, input logic [11:0] i_rgb);
    logic [5:0] q [3];
    int row, col, fph;
    reset = i_rst; en = i_en; pix_valid = i_pv;
    line_start = i_ls; frame_start = i_fs; rgb_in = i_rgb;
    if (i_fs) begin
      m_frame++;
      m_line = 0;
    end else if (i_ls) begin
      m_line++;
    end
    if (i_fs || i_ls) m_pix = 0;
    row = m_line % 2;
    col = m_pix % 2;
    fph = m_frame % 2;
    q[0] = ref_pix(1, 1, i_rgb, i_en, row, col, fph);
    q[1] = ref_pix(1, 0, i_rgb, i_en, row, col, fph);
    q[2] = ref_pix(0, 1, i_rgb, i_en, row, col, fph);
    if (i_pv) m_pix++;
    @(posedge clk);
    cyc++;
    if (i_rst) begin
      m_frame = 0; m_line = 0; m_pix = 0;
      m_s1_valid = 1'b0; m_out_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        m_s1_q[k] = '0;
        m_out_q[k] = '0;
      end
    end else begin
      m_out_valid = m_s1_valid;
      if (m_s1_valid) for (int k = 0; k < 3; k++) m_out_q[k] = m_s1_q[k];
      m_s1_valid = i_pv;
      for (int k = 0; k < 3; k++) m_s1_q[k] = q[k];
    end
    #1;
    check("model_dt", {val_dt, rgb_dt}, {m_out_valid, m_out_q[0]});
    check("model_ds", {val_ds, rgb_ds}, {m_out_valid, m_out_q[1]});
    check("model_rn", {val_rn, rgb_rn}, {m_out_valid, m_out_q[2]});
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_s1_q[k] = '0;
      m_out_q[k] = '0;
    end
    reset = 1'b1; en = 1'b0; pix_valid = 1'b0;
    line_start = 1'b0; frame_start = 1'b0; rgb_in = '0;

    //        en    pv    ls    fs    rgb      ev    dt         ds         rn
    tv[0]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 12'h777, 1'b1, 6'b101010, 6'b101010, 6'b010101);
    tv[1]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 12'h777, 1'b1, 6'b010101, 6'b010101, 6'b010101);
    tv[2]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 12'h777, 1'b1, 6'b010101, 6'b010101, 6'b010101);
    tv[3]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 12'h777, 1'b1, 6'b101010, 6'b101010, 6'b010101);
    tv[4]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 12'h05A, 1'b1, 6'b000110, 6'b000110, 6'b000110);
    tv[5]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 12'hF00, 1'b1, 6'b110000, 6'b110000, 6'b110000);
    tv[6]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 12'h8CD, 1'b1, 6'b101111, 6'b101111, 6'b101011);
    tv[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 12'hFFF, 1'b1, 6'b000000, 6'b000000, 6'b000000);
    tv[8]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF, 1'b1, 6'b111111, 6'b111111, 6'b111111);
    tv[9]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 12'h123, 1'b1, 6'b000000, 6'b000000, 6'b000000);
    tv[10] = mk(1'b1, 1'b1, 1'b0, 1'b0, 12'h369, 1'b1, 6'b010110, 6'b011010, 6'b010110);
    tv[11] = mk(1'b1, 1'b1, 1'b0, 1'b0, 12'h4E1, 1'b1, 6'b011100, 6'b011100, 6'b011100);
    tv[12] = mk(1'b1, 1'b1, 1'b0, 1'b1, 12'h666, 1'b1, 6'b101010, 6'b101010, 6'b010101);
    tv[13] = mk(1'b1, 1'b1, 1'b0, 1'b0, 12'h666, 1'b1, 6'b010101, 6'b010101, 6'b010101);
    tv[14] = mk(1'b1, 1'b1, 1'b1, 1'b0, 12'h666, 1'b1, 6'b010101, 6'b010101, 6'b010101);
    tv[15] = mk(1'b1, 1'b1, 1'b0, 1'b0, 12'h666, 1'b1, 6'b010101, 6'b010101, 6'b010101);
    tv[16] = mk(1'b1, 1'b1, 1'b1, 1'b1, 12'h666, 1'b1, 6'b010101, 6'b101010, 6'b010101);
    tv[17] = mk(1'b1, 1'b1, 1'b0, 1'b0, 12'h666, 1'b1, 6'b010101, 6'b010101, 6'b010101);
    tv[18] = mk(1'b1, 1'b1, 1'b1, 1'b0, 12'h666, 1'b1, 6'b010101, 6'b010101, 6'b010101);
    tv[19] = mk(1'b1, 1'b1, 1'b0, 1'b0, 12'h666, 1'b1, 6'b101010, 6'b010101, 6'b010101);
    tv[20] = mk(1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 6'b101010, 6'b010101, 6'b010101);
    tv[21] = mk(1'b1, 1'b1, 1'b0, 1'b0, 12'h666, 1'b1, 6'b010101, 6'b101010, 6'b010101);

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    check("reset_dt", {val_dt, rgb_dt}, 7'd0);
    check("reset_ds", {val_ds, rgb_ds}, 7'd0);
    check("reset_rn", {val_rn, rgb_rn}, 7'd0);

    // Vector i becomes visible on the sample taken after step i+1.
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) step(1'b0, tv[i].en, tv[i].pv, tv[i].ls, tv[i].fs, tv[i].rgb);
      else        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
      if (i >= 1) begin
        check($sformatf("vec%0d_dt", i - 1), {val_dt, rgb_dt}, {tv[i-1].ev, tv[i-1].e_dt});
        check($sformatf("vec%0d_ds", i - 1), {val_ds, rgb_ds}, {tv[i-1].ev, tv[i-1].e_ds});
        check($sformatf("vec%0d_rn", i - 1), {val_rn, rgb_rn}, {tv[i-1].ev, tv[i-1].e_rn});
      end
    end

    // Reset while pixels are in flight: the second pixel must never emerge.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'hFFF);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF);
    check("pre_reset_dt", {val_dt, rgb_dt}, 7'b1_111111);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'hFFF);
    check("in_reset_dt", {val_dt, rgb_dt}, 7'd0);
    check("in_reset_rn", {val_rn, rgb_rn}, 7'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    check("post_reset_ds", {val_ds, rgb_ds}, 7'd0);
    check("post_reset_dt", {val_dt, rgb_dt}, 7'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h777);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    check("restart_ds", {val_ds, rgb_ds}, 7'b1_101010);
    check("restart_dt", {val_dt, rgb_dt}, 7'b1_101010);
    check("restart_rn", {val_rn, rgb_rn}, 7'b1_010101);

    for (int n = 0; n < 500; n++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 12) == 0),
           ($urandom_range(0, 40) == 0),
           12'($urandom_range(0, 4095)));
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
